// File: rtl/tdm_mux.sv
// tdm_mux: N-channel, WIDTH-bit registered multiplexer with a manual select
// mode and a round-robin scan mode that skips idle channels after a dwell.
//
// Optional feature: define TDM_MUX_PARITY_EN to add out_parity, the XOR
// reduction of the captured word, registered alongside out_data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   data_in    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (combinational)
//   mode       0 = manual (sel), 1 = round-robin scan
//   sel        manual-mode channel index
//   onehot     decoded current channel (combinational), zero if none
//   out_data   registered output word
//   out_ch     channel index of out_data
//   out_valid  output register holds a word
//   out_ready  downstream accept
//   out_parity (TDM_MUX_PARITY_EN only) parity of out_data
module tdm_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH*WIDTH-1:0]      data_in,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  input  logic                       mode,
  input  logic [$clog2(N_CH)-1:0]    sel,
  output logic [N_CH-1:0]            onehot,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_CH)-1:0]    out_ch,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef TDM_MUX_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned DW_W  = $clog2(DWELL) + 1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [SEL_W-1:0]   w_ptr_inc;
  logic [SEL_W-1:0]   w_cur;
  logic [DW_W-1:0]    r_dwell;
  logic [DW_W-1:0]    w_dwell_nxt;
  logic [WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]   w_cap_data;
  logic [SEL_W-1:0]   r_out_ch;
  logic               r_out_valid;
  logic               w_load_ok;
  logic               w_capture;
  logic [N_CH-1:0]    w_onehot;
`ifdef TDM_MUX_PARITY_EN
  logic               r_parity;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: mode is sampled every edge and takes effect the next cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MANUAL: if (mode)  w_state_nxt = ST_SCAN;
      ST_SCAN:   if (!mode) w_state_nxt = ST_MANUAL;
      default:   w_state_nxt = ST_MANUAL;
    endcase
  end

  // Outputs of the FSM: current channel decode, load enable and capture
  always_comb begin
    w_cur      = (r_state == ST_SCAN) ? r_ptr : sel;
    w_load_ok  = !r_out_valid || out_ready;
    w_onehot   = '0;
    w_cap_data = '0;
    // Out-of-range indices match no channel, so nothing is selected
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_cur == SEL_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_cap_data  = data_in[i*WIDTH +: WIDTH];
      end
    end
    w_capture = (|(w_onehot & in_valid)) && w_load_ok;
  end

  // Scan pointer and dwell counter; stalls (load_ok=0) freeze both
  always_comb begin
    w_ptr_inc   = (r_ptr == SEL_W'(N_CH - 1)) ? '0 : r_ptr + SEL_W'(1);
    w_ptr_nxt   = r_ptr;
    w_dwell_nxt = r_dwell;
    if (r_state == ST_SCAN) begin
      if (w_capture) begin
        w_ptr_nxt   = w_ptr_inc;
        w_dwell_nxt = '0;
      end else if (w_load_ok) begin
        // ptr is always in range in scan, so no capture here means idle
        if (r_dwell == DW_W'(DWELL - 1)) begin
          w_ptr_nxt   = w_ptr_inc;
          w_dwell_nxt = '0;
        end else begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end
      end
    end else if (mode) begin
      w_ptr_nxt   = (32'(sel) < N_CH) ? sel : '0;
      w_dwell_nxt = '0;
    end
  end

  // Pointer, dwell and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_dwell     <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_dwell <= w_dwell_nxt;
      if (w_capture) begin
        r_out_data  <= w_cap_data;
        r_out_ch    <= w_cur;
        r_out_valid <= 1'b1;
`ifdef TDM_MUX_PARITY_EN
        r_parity    <= ^w_cap_data;
`endif
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign onehot    = w_onehot;
  assign in_ready  = w_load_ok ? w_onehot : '0;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
`ifdef TDM_MUX_PARITY_EN
  assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: a 4-channel (DWELL=4) and a 3-channel
// (DWELL=2) instance run side by side against a cycle-level reference model.
module tb_tdm_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: N_CH=4, WIDTH=8, DWELL=4
  logic [31:0] a_data;
  logic [3:0]  a_iv, a_ir, a_oh;
  logic        a_mode, a_ordy, a_ov;
  logic [1:0]  a_sel, a_och;
  logic [7:0]  a_od;
  // Instance B: N_CH=3, WIDTH=8, DWELL=2
  logic [23:0] b_data;
  logic [2:0]  b_iv, b_ir, b_oh;
  logic        b_mode, b_ordy, b_ov;
  logic [1:0]  b_sel, b_och;
  logic [7:0]  b_od;
`ifdef TDM_MUX_PARITY_EN
  logic        a_par, b_par;
`endif

  tdm_mux #(.N_CH(4), .WIDTH(8), .DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .in_valid(a_iv),
    .in_ready(a_ir), .mode(a_mode), .sel(a_sel), .onehot(a_oh),
    .out_data(a_od), .out_ch(a_och), .out_valid(a_ov), .out_ready(a_ordy)
`ifdef TDM_MUX_PARITY_EN
    , .out_parity(a_par)
`endif
  );

  tdm_mux #(.N_CH(3), .WIDTH(8), .DWELL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .in_valid(b_iv),
    .in_ready(b_ir), .mode(b_mode), .sel(b_sel), .onehot(b_oh),
    .out_data(b_od), .out_ch(b_och), .out_valid(b_ov), .out_ready(b_ordy)
`ifdef TDM_MUX_PARITY_EN
    , .out_parity(b_par)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state, index 0 = instance A, 1 = instance B
  int         m_scan[2];
  int         m_ptr[2];
  int         m_idle[2];
  int         m_ov[2];
  int         m_och[2];
  int         m_par[2];
  logic [7:0] m_od[2];

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction
  function automatic int dwl(input int k);
    return (k == 0) ? 4 : 2;
  endfunction
  function automatic logic [31:0] data_of(input int k);
    if (k == 0) return a_data;
    return {8'h00, b_data};
  endfunction
  function automatic logic [3:0] iv_of(input int k);
    if (k == 0) return a_iv;
    return {1'b0, b_iv};
  endfunction
  function automatic int sel_of(input int k);
    return (k == 0) ? int'(a_sel) : int'(b_sel);
  endfunction
  function automatic logic mode_of(input int k);
    return (k == 0) ? a_mode : b_mode;
  endfunction
  function automatic logic ordy_of(input int k);
    return (k == 0) ? a_ordy : b_ordy;
  endfunction
  function automatic int cur_of(input int k);
    return (m_scan[k] != 0) ? m_ptr[k] : sel_of(k);
  endfunction
  function automatic logic [3:0] exp_oh(input int k);
    int c;
    c = cur_of(k);
    return (c < nch(k)) ? 4'(1 << c) : 4'b0000;
  endfunction
  function automatic logic [3:0] exp_ir(input int k);
    return (m_ov[k] == 0 || ordy_of(k)) ? exp_oh(k) : 4'b0000;
  endfunction

  // One clock edge of the model: idle-cycle count per channel, round-robin modulo N
  task automatic model_step(input int k);
    int          n, c;
    logic        lok, cap;
    logic [31:0] d;
    logic [3:0]  iv;
    if (!rst_n) begin
      m_scan[k] = 0; m_ptr[k] = 0; m_idle[k] = 0;
      m_ov[k] = 0; m_od[k] = 8'h00; m_och[k] = 0; m_par[k] = 0;
      return;
    end
    n   = nch(k);
    c   = cur_of(k);
    d   = data_of(k);
    iv  = iv_of(k);
    lok = (m_ov[k] == 0) || ordy_of(k);
    cap = (c < n) && iv[2'(c)] && lok;
    if (m_scan[k] != 0) begin
      if (cap) begin
        m_ptr[k]  = (m_ptr[k] + 1) % n;
        m_idle[k] = 0;
      end else if (lok) begin
        m_idle[k]++;
        if (m_idle[k] == dwl(k)) begin
          m_ptr[k]  = (m_ptr[k] + 1) % n;
          m_idle[k] = 0;
        end
      end
    end else if (mode_of(k)) begin
      m_ptr[k]  = (sel_of(k) < n) ? sel_of(k) : 0;
      m_idle[k] = 0;
    end
    m_scan[k] = mode_of(k) ? 1 : 0;
    if (cap) begin
      m_od[k]  = d[c*8 +: 8];
      m_och[k] = c;
      m_ov[k]  = 1;
      m_par[k] = int'(^d[c*8 +: 8]);
    end else if (m_ov[k] != 0 && ordy_of(k)) begin
      m_ov[k] = 0;
    end
  endtask

  task automatic comb_checks();
    check("a_onehot", 32'(a_oh), 32'(exp_oh(0)));
    check("a_ready",  32'(a_ir), 32'(exp_ir(0)));
    check("b_onehot", 32'(b_oh), 32'(exp_oh(1) & 4'b0111));
    check("b_ready",  32'(b_ir), 32'(exp_ir(1) & 4'b0111));
  endtask

  task automatic reg_checks();
    check("a_valid", 32'(a_ov),  32'(m_ov[0]));
    check("a_data",  32'(a_od),  32'(m_od[0]));
    check("a_ch",    32'(a_och), 32'(m_och[0]));
    check("b_valid", 32'(b_ov),  32'(m_ov[1]));
    check("b_data",  32'(b_od),  32'(m_od[1]));
    check("b_ch",    32'(b_och), 32'(m_och[1]));
`ifdef TDM_MUX_PARITY_EN
    check("a_parity", 32'(a_par), 32'(m_par[0]));
    check("b_parity", 32'(b_par), 32'(m_par[1]));
`endif
  endtask

  task automatic settle();
    #1;
  endtask

  // Inputs are set before calling; checks combinational outputs, clocks, checks registers
  task automatic tick();
    #1;
    if (armed) comb_checks();
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (!rst_n) armed = 1'b1;
    #1;
    if (armed) reg_checks();
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int b_rr_exp[4] = '{0, 1, 2, 0};

  initial begin
    a_data = 32'h44332211; a_iv = 4'b0100; a_mode = 1'b0; a_sel = 2'd2; a_ordy = 1'b1;
    b_data = 24'h0;        b_iv = 3'b000;  b_mode = 1'b0; b_sel = 2'd0; b_ordy = 1'b1;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    check("rst_valid", 32'(a_ov), 32'd0);
    check("rst_data",  32'(a_od), 32'd0);
    rst_n = 1'b1;

    // Manual select of channel 2
    settle();
    check("man_onehot", 32'(a_oh), 32'h4);
    check("man_ready",  32'(a_ir), 32'h4);
    tick();
    check("man_data",  32'(a_od),  32'h33);
    check("man_ch",    32'(a_och), 32'd2);
    check("man_valid", 32'(a_ov),  32'd1);

    // Backpressure: word held, no ready, data changing underneath
    a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = $urandom;
      settle();
      check("bp_ready", 32'(a_ir), 32'd0);
      tick();
      check("bp_data",  32'(a_od), 32'h33);
      check("bp_valid", 32'(a_ov), 32'd1);
    end
    a_ordy = 1'b1;
    a_data = 32'h005A0000;
    tick();
    check("bp_new_data",  32'(a_od), 32'h5A);
    check("bp_new_valid", 32'(a_ov), 32'd1);

    // Scan round-robin from sel=0 with every channel valid
    a_data = 32'h44332211; a_iv = 4'hF; a_sel = 2'd0; a_mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_ch",    32'(a_och), 32'(rr_exp[i]));
      check("rr_valid", 32'(a_ov),  32'd1);
    end

    // Dwell skip: ptr=1, only ch0 and ch3 valid
    a_iv = 4'b1001;
    for (int i = 1; i <= 9; i++) begin
      settle();
      check("dw_onehot", 32'(a_oh), (i <= 4) ? 32'h2 : ((i <= 8) ? 32'h4 : 32'h8));
      tick();
    end
    check("dw_ch3",    32'(a_och), 32'd3);
    check("dw_data3",  32'(a_od),  32'h44);
    check("dw_valid3", 32'(a_ov),  32'd1);

    // Capture ch0, then stall two cycles at the start of ch1's dwell
    tick();
    for (int i = 1; i <= 7; i++) begin
      a_ordy = (i <= 2) ? 1'b0 : 1'b1;
      settle();
      check("stall_onehot", 32'(a_oh), (i <= 6) ? 32'h2 : 32'h4);
      tick();
    end

    // Parity captures in manual mode, then reset while a word is held
    a_mode = 1'b0; a_sel = 2'd0; a_iv = 4'b0001; a_data = 32'h00000007;
    tick();
    tick();
    check("par_data7", 32'(a_od), 32'h07);
`ifdef TDM_MUX_PARITY_EN
    check("par_7", 32'(a_par), 32'd1);
`endif
    a_data = 32'h00000003;
    tick();
    check("par_data3", 32'(a_od), 32'h03);
`ifdef TDM_MUX_PARITY_EN
    check("par_3", 32'(a_par), 32'd0);
`endif
    a_ordy = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("mrst_valid", 32'(a_ov),  32'd0);
    check("mrst_data",  32'(a_od),  32'd0);
    check("mrst_ch",    32'(a_och), 32'd0);
    rst_n  = 1'b1;
    a_ordy = 1'b1;

    // Instance B: out-of-range select, then non-power-of-2 scan wrap
    b_data = 24'hCCBBAA; b_iv = 3'b111; b_sel = 2'd0;
    tick();
    check("b_cap0", 32'(b_od), 32'hAA);
    b_sel = 2'd3;
    settle();
    check("oor_onehot", 32'(b_oh), 32'd0);
    check("oor_ready",  32'(b_ir), 32'd0);
    tick();
    check("oor_drain", 32'(b_ov), 32'd0);
    tick();
    check("oor_idle",  32'(b_ov), 32'd0);
    b_mode = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_rr_ch", 32'(b_och), 32'(b_rr_exp[i]));
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      a_data = $urandom;
      b_data = 24'($urandom);
      a_iv   = 4'($urandom);
      b_iv   = 3'($urandom);
      a_sel  = 2'($urandom);
      b_sel  = 2'($urandom);
      a_ordy = ($urandom_range(0, 3) != 0);
      b_ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
